uart_alu_ctrl: RTL and testbench

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

---
 rtl/uart_alu_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_alu_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
// Purpose : collects a 3-byte UART frame (A, B, opcode), drives the ALU and sends back its result byte.
// Latency : tx_start pulses 2 cycles after the edge that samples the opcode byte's rx_done.
// Backpr. : none on rx; bytes arriving while a result is in flight (EXEC/SEND/WAIT_TX) are dropped.
//
// Ports
//   clock, reset          single clock domain, synchronous active-low reset
//   tick                  baud-rate tick, drives the inter-byte timeout
//   rx_done, rx_data      received byte strobe and data
//   tx_done               transmitter finished the current byte
//   alu_result            combinational ALU output for data_a/data_b/op
//   data_a, data_b, op    registered ALU operands and opcode
//   tx_start, tx_data     one-cycle transmit request and the byte to send
//   busy                  high whenever not idle waiting for operand A
//   timeout_err           one-cycle pulse when a partial frame is discarded
module uart_alu_ctrl #(
    parameter int N_BITS    = 8,
    parameter int N_OP      = 6,
    parameter int N_TIMEOUT = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              rx_done,
    input  logic [N_BITS-1:0] rx_data,
    input  logic              tx_done,
    input  logic [N_BITS-1:0] alu_result,
    output logic [N_BITS-1:0] data_a,
    output logic [N_BITS-1:0] data_b,
    output logic [N_OP-1:0]   op,
    output logic              tx_start,
    output logic [N_BITS-1:0] tx_data,
    output logic              busy,
    output logic              timeout_err
);

    localparam int            CW     = $clog2(N_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(N_TIMEOUT);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        SEND,
        WAIT_TX
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          timed_out;

    // The limit is checked on the registered count, so the discard happens
    // on the edge after the N_TIMEOUT-th tick; an rx_done on that tick or on
    // the discard edge itself still takes priority.
    assign timed_out = (cnt == TO_MAX);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= GET_A;
            cnt         <= '0;
            data_a      <= '0;
            data_b      <= '0;
            op          <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                GET_A: begin
                    cnt <= '0;
                    if (rx_done) begin
                        data_a <= rx_data;
                        state  <= GET_B;
                        busy   <= 1'b1;
                    end
                end
                GET_B: begin
                    if (rx_done) begin
                        data_b <= rx_data;
                        cnt    <= '0;
                        state  <= GET_OP;
                    end else if (timed_out) begin
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        state       <= GET_A;
                        busy        <= 1'b0;
                    end else if (tick) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GET_OP: begin
                    if (rx_done) begin
                        op    <= rx_data[N_OP-1:0];
                        cnt   <= '0;
                        state <= EXEC;
                    end else if (timed_out) begin
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        state       <= GET_A;
                        busy        <= 1'b0;
                    end else if (tick) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                EXEC: begin
                    // Operands and opcode settled last edge; capture the ALU.
                    tx_data <= alu_result;
                    state   <= SEND;
                end
                SEND: begin
                    tx_start <= 1'b1;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        cnt   <= '0;
                        state <= GET_A;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= GET_A;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Purpose : directed, table-driven self-checking bench for uart_alu_ctrl.
// Latency : inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpr. : not applicable; the bench emulates the ALU combinationally.
module tb_uart_alu_ctrl;

    localparam int TO = 16;

    logic       clock;
    logic       reset;
    logic       tick;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    uart_alu_ctrl #(.N_BITS(8), .N_OP(6), .N_TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .tx_done     (tx_done),
        .alu_result  (alu_result),
        .data_a      (data_a),
        .data_b      (data_b),
        .op          (op),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ALU emulation: 0x20 add, 0x22 subtract, anything else xor.
    always_comb begin
        case (op)
            6'h20:   alu_result = data_a + data_b;
            6'h22:   alu_result = data_a - data_b;
            default: alu_result = data_a ^ data_b;
        endcase
    end

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [5:0] exp_op;
        logic [7:0] exp_res;
        logic       extra;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
    endtask

    // Called right after the opcode byte's rx_done edge.
    task automatic finish_frame(input string tag, input logic [7:0] exp_res, input logic extra,
                                input logic [7:0] exp_a);
        chk({tag, "_txs_exec"}, tx_start, 0);
        cyc();
        chk({tag, "_txs_send"}, tx_start, 0);
        cyc();
        chk({tag, "_txs_lat2"}, tx_start, 1);
        chk({tag, "_txdata"}, tx_data, exp_res);
        cyc();
        chk({tag, "_txs_pulse"}, tx_start, 0);
        if (extra) begin
            send_byte(8'hFF);
            chk({tag, "_drop_a"}, data_a, exp_a);
            chk({tag, "_drop_busy"}, busy, 1);
        end
        cyc();
        cyc();
        chk({tag, "_txdata_hold"}, tx_data, exp_res);
        chk({tag, "_busy_wait"}, busy, 1);
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_txs_done"}, tx_start, 0);
    endtask

    initial begin
        int errs;
        int starts;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 1'b1};
        vecs[1] = '{8'h01, 8'h02, 8'h20, 6'h20, 8'h03, 1'b0};
        vecs[2] = '{8'h10, 8'h04, 8'hE2, 6'h22, 8'h0C, 1'b0};
        vecs[3] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00, 1'b0};
        vecs[4] = '{8'h0A, 8'h03, 8'h26, 6'h26, 8'h09, 1'b0};
        vecs[5] = '{8'hC0, 8'h05, 8'hA0, 6'h20, 8'hC5, 1'b0};

        reset   = 1'b0;
        tick    = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_done = 1'b0;
        cyc();
        cyc();
        chk("rst_data_a", data_a, 0);
        chk("rst_data_b", data_b, 0);
        chk("rst_op", op, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b1;
        cyc();

        // tx_done and tick while idle must do nothing
        tx_done = 1'b1;
        tick    = 1'b1;
        cyc();
        tx_done = 1'b0;
        tick    = 1'b0;
        cyc();
        chk("idle_txdone_busy", busy, 0);
        chk("idle_txdone_txs", tx_start, 0);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            send_byte(vecs[i].a);
            chk({tag, "_busy_a"}, busy, 1);
            chk({tag, "_data_a"}, data_a, vecs[i].a);
            send_byte(vecs[i].b);
            chk({tag, "_data_b"}, data_b, vecs[i].b);
            send_byte(vecs[i].opb);
            chk({tag, "_op"}, op, vecs[i].exp_op);
            finish_frame(tag, vecs[i].exp_res, vecs[i].extra, vecs[i].a);
        end

        // Partial frame abandoned after TO ticks
        send_byte(8'h11);
        send_byte(8'h22);
        errs = 0;
        tick = 1'b1;
        for (int k = 0; k < TO - 1; k++) begin
            cyc();
            if (timeout_err) errs++;
        end
        chk("to_early_err", errs, 0);
        chk("to_early_busy", busy, 1);
        cyc();
        if (timeout_err) errs++;
        tick = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (timeout_err) errs++;
        end
        chk("to_pulse_count", errs, 1);
        chk("to_busy", busy, 0);
        chk("to_keep_a", data_a, 8'h11);
        chk("to_keep_b", data_b, 8'h22);
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        chk("to_fresh_op", op, 6'h20);
        finish_frame("to_fresh", 8'h08, 1'b0, 8'h05);

        // rx_done coincident with the TO-th tick wins
        send_byte(8'h33);
        errs = 0;
        tick = 1'b1;
        for (int k = 0; k < TO - 1; k++) begin
            cyc();
            if (timeout_err) errs++;
        end
        rx_data = 8'h44;
        rx_done = 1'b1;
        cyc();
        if (timeout_err) errs++;
        rx_done = 1'b0;
        tick    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (timeout_err) errs++;
        end
        chk("race_err", errs, 0);
        chk("race_data_b", data_b, 8'h44);
        chk("race_busy", busy, 1);
        send_byte(8'h20);
        chk("race_op", op, 6'h20);
        finish_frame("race", 8'h77, 1'b0, 8'h33);

        // Reset while waiting on the transmitter
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        cyc();
        cyc();
        chk("rw_txs_before", tx_start, 1);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("rw_data_a", data_a, 0);
        chk("rw_data_b", data_b, 0);
        chk("rw_op", op, 0);
        chk("rw_tx_data", tx_data, 0);
        chk("rw_tx_start", tx_start, 0);
        chk("rw_busy", busy, 0);
        chk("rw_timeout_err", timeout_err, 0);
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        starts = 0;
        for (int k = 0; k < 6; k++) begin
            if (tx_start) starts++;
            cyc();
        end
        chk("rw_no_start", starts, 0);
        chk("rw_busy_after", busy, 0);

        // Reset mid-frame: the next byte must start a new frame
        send_byte(8'h07);
        send_byte(8'h08);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        chk("rf_busy", busy, 0);
        send_byte(8'h20);
        chk("rf_data_a", data_a, 8'h20);
        chk("rf_busy_a", busy, 1);
        starts = 0;
        for (int k = 0; k < 5; k++) begin
            if (tx_start) starts++;
            cyc();
        end
        chk("rf_no_start", starts, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
